// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port RAM between the CPU data port and
// the VGA pixel fetcher.
//
// Each access takes three cycles: IDLE (arbitrate), ACC (address, and write
// enable for CPU stores, on the RAM) and DATA (read data captured, ACK pulses).
// The request is sampled in IDLE and its ACK is seen two cycles later.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. Without it, VGA always wins a tie and there is no
// last-grant register.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU access request (held until cpu_ack)
//   vga_req, vga_address  VGA pixel read request (held until vga_ack)
//   read_mem_data         RAM read data for the address on mem_addr
//   mem_addr, write_mem_en, write_mem_data   RAM control
//   cpu_ack, cpu_rdata    CPU completion pulse and load data
//   cpu_stall             cpu_req & ~cpu_ack
//   vga_ack, read_pixel   VGA completion pulse and pixel data
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             vga_req,
    input  logic [WIDTH-1:0] vga_address,
    input  logic [WIDTH-1:0] read_mem_data,
    output logic [WIDTH-1:0] mem_addr,
    output logic             write_mem_en,
    output logic [WIDTH-1:0] write_mem_data,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             vga_ack,
    output logic [WIDTH-1:0] read_pixel
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_ACC  = 3'd1;
    localparam logic [2:0] VGA_ACC  = 3'd2;
    localparam logic [2:0] CPU_DATA = 3'd3;
    localparam logic [2:0] VGA_DATA = 3'd4;

    logic [2:0] state;
    logic       grant_vga;
    logic       grant_cpu;

`ifdef MEM_ARB_RR_EN
    // 1 = CPU held the most recent grant; on a tie the other side wins.
    logic last_cpu;

    assign grant_vga = vga_req & (~cpu_req | last_cpu);
`else
    assign grant_vga = vga_req;
`endif
    assign grant_cpu = cpu_req & ~grant_vga;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mem_addr       <= '0;
            write_mem_en   <= 1'b0;
            write_mem_data <= '0;
            cpu_ack        <= 1'b0;
            cpu_rdata      <= '0;
            vga_ack        <= 1'b0;
            read_pixel     <= '0;
`ifdef MEM_ARB_RR_EN
            last_cpu       <= 1'b1;
`endif
        end else begin
            // Enables and ACKs are single-cycle pulses; every state that
            // needs one sets it explicitly below.
            write_mem_en <= 1'b0;
            cpu_ack      <= 1'b0;
            vga_ack      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vga) begin
                        state    <= VGA_ACC;
                        mem_addr <= vga_address;
`ifdef MEM_ARB_RR_EN
                        last_cpu <= 1'b0;
`endif
                    end else if (grant_cpu) begin
                        state          <= CPU_ACC;
                        mem_addr       <= cpu_addr;
                        write_mem_en   <= cpu_we;
                        write_mem_data <= cpu_wdata;
`ifdef MEM_ARB_RR_EN
                        last_cpu       <= 1'b1;
`endif
                    end
                end
                CPU_ACC: begin
                    // write_mem_en still holds the latched WE here, so it
                    // tells a store (keep old load data) from a load.
                    state   <= CPU_DATA;
                    cpu_ack <= 1'b1;
                    if (!write_mem_en)
                        cpu_rdata <= read_mem_data;
                end
                VGA_ACC: begin
                    state      <= VGA_DATA;
                    vga_ack    <= 1'b1;
                    read_pixel <= read_mem_data;
                end
                CPU_DATA, VGA_DATA: state <= IDLE;
                default:            state <= IDLE;
            endcase
        end
    end

endmodule
